// File: rtl/sad_buf_pkg.sv
// sad_buf_pkg: shared widths, arbiter state encoding and log2 helper
package sad_buf_pkg;
  localparam int PIXEL_SIZE_DEF = 12;
  localparam int BUF_ADDR_WIDTH_DEF = 14;
  typedef enum logic [1:0] {ARB, ISSUE, RESP} arb_state_t;
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant from a request vector and start pointer
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  localparam logic [IW:0] NV = N[IW:0];
  logic [N-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  assign rot = N'({req, req} >> ptr);
  assign any = |req;
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) off = IW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= NV) ? IW'(sum - NV) : sum[IW-1:0];
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/image_buffer_rd_arbiter.sv
// image_buffer_rd_arbiter: round-robin sharing of the image_buffer read port with timeout watchdog
module image_buffer_rd_arbiter
  import sad_buf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int BUF_ADDR_WIDTH = BUF_ADDR_WIDTH_DEF,
  parameter int PIXEL_SIZE = PIXEL_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*BUF_ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [PIXEL_SIZE-1:0]             rsp_data,
  output logic                              rsp_err,
  output logic [BUF_ADDR_WIDTH-1:0]         buf_raddr,
  output logic                              buf_rvalid,
  input  logic                              buf_rready,
  input  logic [PIXEL_SIZE-1:0]             buf_rdata,
  output logic                              timeout_err
);
  localparam int IW = log2(NUM_REQ);
  localparam int CW = log2(TIMEOUT_CYCLES) + 1;
  arb_state_t state;
  logic [IW-1:0] ptr, idx;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] gnt, gsel;
  logic any;
  logic [BUF_ADDR_WIDTH-1:0] sel_addr;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  // acceptance is visible in the ARB cycle itself so requesters can drop valid next cycle
  assign req_ready = (rst_n && state == ARB) ? gnt : '0;
  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) if (gnt[k]) sel_addr = req_addr[k*BUF_ADDR_WIDTH +: BUF_ADDR_WIDTH];
  end
  // ready is checked before the watchdog, so a last-cycle ready still succeeds
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= ARB;
      ptr <= '0;
      cnt <= '0;
      gsel <= '0;
      buf_raddr <= '0;
      buf_rvalid <= 1'b0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      timeout_err <= 1'b0;
    end else
      case (state)
        ARB: if (any) begin
          gsel <= gnt;
          buf_raddr <= sel_addr;
          buf_rvalid <= 1'b1;
          ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (buf_rready || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data <= buf_rready ? buf_rdata : '0;
          rsp_err <= !buf_rready;
          timeout_err <= timeout_err | !buf_rready;
          rsp_valid <= gsel;
          buf_rvalid <= 1'b0;
          state <= RESP;
        end else cnt <= cnt + 1'b1;
        default: begin
          rsp_valid <= '0;
          rsp_err <= 1'b0;
          cnt <= '0;
          state <= ARB;
        end
      endcase
endmodule

// File: tb/tb_image_buffer_rd_arbiter.sv
// tb_image_buffer_rd_arbiter: table-driven and directed checks of the read-port arbiter
module tb_image_buffer_rd_arbiter;
  localparam int AW = 14;
  localparam int PW = 12;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [PW-1:0] rsp_data, buf_rdata;
  logic rsp_err, buf_rvalid, buf_rready, timeout_err;
  logic [AW-1:0] buf_raddr;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  image_buffer_rd_arbiter #(
    .NUM_REQ(2), .BUF_ADDR_WIDTH(AW), .PIXEL_SIZE(PW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .buf_raddr(buf_raddr), .buf_rvalid(buf_rvalid), .buf_rready(buf_rready),
    .buf_rdata(buf_rdata), .timeout_err(timeout_err)
  );
  typedef struct {
    logic rst_n;
    logic [1:0] rv;
    logic [AW-1:0] a0, a1;
    logic rdy;
    logic [PW-1:0] rd;
    logic [1:0] rr, rsv;
    logic [PW-1:0] rsd;
    logic err;
    logic [AW-1:0] raddr;
    logic brv, to;
  } vec_t;
  vec_t tv[24];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic [1:0] v, input logic [AW-1:0] x0, input logic [AW-1:0] x1,
                       input logic rdy, input logic [PW-1:0] d);
    rst_n = r;
    req_valid = v;
    req_addr = {x1, x0};
    buf_rready = rdy;
    buf_rdata = d;
  endtask
  task automatic expect_out(input string tag, input logic [1:0] rr, input logic [1:0] rsv, input logic [PW-1:0] rsd,
                            input logic err, input logic [AW-1:0] ra, input logic brv, input logic to);
    @(negedge clk);
    chk($sformatf("%s.req_ready", tag), 32'(req_ready), 32'(rr));
    chk($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'(rsv));
    chk($sformatf("%s.rsp_data", tag), 32'(rsp_data), 32'(rsd));
    chk($sformatf("%s.rsp_err", tag), 32'(rsp_err), 32'(err));
    chk($sformatf("%s.buf_raddr", tag), 32'(buf_raddr), 32'(ra));
    chk($sformatf("%s.buf_rvalid", tag), 32'(buf_rvalid), 32'(brv));
    chk($sformatf("%s.timeout_err", tag), 32'(timeout_err), 32'(to));
  endtask
  initial begin
    tv[0]  = '{0, 2'b00, 123, 0, 1, 'hABC, 2'b00, 2'b00, 'h000, 0, 0, 0, 0};
    tv[1]  = '{1, 2'b01, 123, 0, 1, 'hABC, 2'b01, 2'b00, 'h000, 0, 0, 0, 0};
    tv[2]  = '{1, 2'b00, 123, 0, 1, 'hABC, 2'b00, 2'b00, 'h000, 0, 123, 1, 0};
    tv[3]  = '{1, 2'b00, 123, 0, 1, 'hABC, 2'b00, 2'b01, 'hABC, 0, 123, 0, 0};
    tv[4]  = '{0, 2'b00, 123, 0, 1, 'hABC, 2'b00, 2'b00, 'hABC, 0, 123, 0, 0};
    tv[5]  = '{1, 2'b11, 10, 20, 1, 'h111, 2'b01, 2'b00, 'h000, 0, 0, 0, 0};
    tv[6]  = '{1, 2'b11, 10, 20, 1, 'h111, 2'b00, 2'b00, 'h000, 0, 10, 1, 0};
    tv[7]  = '{1, 2'b11, 10, 20, 1, 'h222, 2'b00, 2'b01, 'h111, 0, 10, 0, 0};
    tv[8]  = '{1, 2'b11, 10, 20, 1, 'h222, 2'b10, 2'b00, 'h111, 0, 10, 0, 0};
    tv[9]  = '{1, 2'b11, 10, 20, 1, 'h222, 2'b00, 2'b00, 'h111, 0, 20, 1, 0};
    tv[10] = '{1, 2'b11, 10, 20, 1, 'h333, 2'b00, 2'b10, 'h222, 0, 20, 0, 0};
    tv[11] = '{1, 2'b11, 10, 20, 1, 'h333, 2'b01, 2'b00, 'h222, 0, 20, 0, 0};
    tv[12] = '{1, 2'b11, 10, 20, 1, 'h333, 2'b00, 2'b00, 'h222, 0, 10, 1, 0};
    tv[13] = '{1, 2'b11, 10, 20, 1, 'h444, 2'b00, 2'b01, 'h333, 0, 10, 0, 0};
    tv[14] = '{1, 2'b11, 10, 20, 0, 'h444, 2'b10, 2'b00, 'h333, 0, 10, 0, 0};
    for (int i = 15; i < 20; i++) tv[i] = '{1, 2'b00, 10, 20, 0, 'h444, 2'b00, 2'b00, 'h333, 0, 20, 1, 0};
    tv[20] = '{1, 2'b00, 10, 20, 1, 'h444, 2'b00, 2'b00, 'h333, 0, 20, 1, 0};
    tv[21] = '{1, 2'b00, 10, 20, 1, 'h444, 2'b00, 2'b10, 'h444, 0, 20, 0, 0};
    tv[22] = '{1, 2'b00, 10, 20, 1, 'h555, 2'b00, 2'b00, 'h444, 0, 20, 0, 0};
    tv[23] = '{1, 2'b00, 10, 20, 0, 'h555, 2'b00, 2'b00, 'h444, 0, 20, 0, 0};
    drive(0, 2'b00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      drive(tv[i].rst_n, tv[i].rv, tv[i].a0, tv[i].a1, tv[i].rdy, tv[i].rd);
      expect_out($sformatf("v%0d", i), tv[i].rr, tv[i].rsv, tv[i].rsd, tv[i].err, tv[i].raddr, tv[i].brv, tv[i].to);
      tick();
    end
    // watchdog: buf_rready never rises
    drive(1, 2'b01, 55, 0, 0, 0);
    expect_out("to_arb", 2'b01, 2'b00, 'h444, 0, 20, 0, 0);
    tick();
    for (int i = 0; i < TO; i++) begin
      drive(1, 2'b00, 55, 0, 0, 0);
      expect_out($sformatf("to_issue%0d", i), 2'b00, 2'b00, 'h444, 0, 55, 1, 0);
      tick();
    end
    expect_out("to_resp", 2'b00, 2'b01, 'h000, 1, 55, 0, 1);
    tick();
    drive(1, 2'b01, 77, 0, 1, 'h5A5);
    expect_out("after_to_arb", 2'b01, 2'b00, 'h000, 0, 55, 0, 1);
    tick();
    drive(1, 2'b00, 77, 0, 1, 'h5A5);
    expect_out("after_to_issue", 2'b00, 2'b00, 'h000, 0, 77, 1, 1);
    tick();
    expect_out("after_to_resp", 2'b00, 2'b01, 'h5A5, 0, 77, 0, 1);
    tick();
    // ready on the final watchdog cycle wins
    drive(1, 2'b01, 9, 0, 0, 'h0F0);
    expect_out("edge_arb", 2'b01, 2'b00, 'h5A5, 0, 77, 0, 1);
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      drive(1, 2'b00, 9, 0, 0, 'h0F0);
      expect_out($sformatf("edge_issue%0d", i), 2'b00, 2'b00, 'h5A5, 0, 9, 1, 1);
      tick();
    end
    drive(1, 2'b00, 9, 0, 1, 'h0F0);
    expect_out("edge_last", 2'b00, 2'b00, 'h5A5, 0, 9, 1, 1);
    tick();
    drive(1, 2'b00, 9, 0, 0, 'h0F0);
    expect_out("edge_resp", 2'b00, 2'b01, 'h0F0, 0, 9, 0, 1);
    tick();
    // reset while in ISSUE drops the transaction and clears the sticky flag
    drive(1, 2'b01, 1, 2, 0, 0);
    expect_out("rst_arb", 2'b01, 2'b00, 'h0F0, 0, 9, 0, 1);
    tick();
    drive(0, 2'b10, 1, 2, 0, 0);
    expect_out("rst_issue", 2'b00, 2'b00, 'h0F0, 0, 1, 1, 1);
    tick();
    drive(1, 2'b10, 1, 2, 1, 'h321);
    expect_out("rst_after", 2'b10, 2'b00, 'h000, 0, 0, 0, 0);
    tick();
    drive(1, 2'b00, 1, 2, 1, 'h321);
    expect_out("rst_r1_issue", 2'b00, 2'b00, 'h000, 0, 2, 1, 0);
    tick();
    expect_out("rst_r1_resp", 2'b00, 2'b10, 'h321, 0, 2, 0, 0);
    tick();
    drive(0, 2'b11, 1, 2, 1, 'h321);
    expect_out("rst2_hold", 2'b00, 2'b00, 'h321, 0, 2, 0, 0);
    tick();
    drive(1, 2'b11, 1, 2, 1, 'h321);
    expect_out("rst2_after", 2'b01, 2'b00, 'h000, 0, 0, 0, 0);
    tick();
    // requester 1 pending during ISSUE/RESP waits for ARB
    drive(1, 2'b10, 1, 2, 1, 'h123);
    expect_out("late_issue", 2'b00, 2'b00, 'h000, 0, 1, 1, 0);
    tick();
    drive(1, 2'b10, 1, 2, 1, 'h456);
    expect_out("late_resp", 2'b00, 2'b01, 'h123, 0, 1, 0, 0);
    tick();
    expect_out("late_arb", 2'b10, 2'b00, 'h123, 0, 1, 0, 0);
    tick();
    drive(1, 2'b00, 1, 2, 1, 'h456);
    expect_out("late_r1_issue", 2'b00, 2'b00, 'h123, 0, 2, 1, 0);
    tick();
    expect_out("late_r1_resp", 2'b00, 2'b10, 'h456, 0, 2, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/image_buffer_rd_arbiter.md
Name: image_buffer_rd_arbiter

Overview:
- Shares the single read port of image_buffer between NUM_REQ requesters, e.g. left/right SAD window fetchers and a debug reader.
- Uses round-robin arbitration with one transaction in flight at a time.
- Holds the buffer-side valid/ready handshake and routes read data back to the winning requester.
- Includes a timeout watchdog so a stalled buffer cannot hang the SAD pipeline.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BUF_ADDR_WIDTH, 14, buffer address width; matches image_buffer (log2 of 100*100).
- PIXEL_SIZE, 12, pixel data width.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for buf_rready before aborting (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*BUF_ADDR_WIDTH  packed addresses; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot, 1-cycle pulse when request i is accepted.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse when the response for requester i is on rsp_data.
- rsp_data  out  PIXEL_SIZE  shared response data.
- rsp_err  out  1  qualifies rsp_valid; 1 means timed out and data is 0.
- buf_raddr  out  BUF_ADDR_WIDTH  to image_buffer.
- buf_rvalid  out  1  to image_buffer.
- buf_rready  in  1  from image_buffer.
- buf_rdata  in  PIXEL_SIZE  from image_buffer; valid when buf_rvalid & buf_rready.
- timeout_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0; state=ARB; priority pointer=0; timeout counter=0.
  - Any in-flight transaction is dropped silently, with no rsp_valid.
- Requester contract: hold req_valid and the address slice stable until req_ready. Deasserting before req_ready is allowed; that request is simply never granted.
- ARB state:
  - If any req_valid is set, grant the first set bit searching from pointer upward, wrapping modulo NUM_REQ.
  - Pulse req_ready[g], latch g and the address, set pointer = (g+1) mod NUM_REQ, go to ISSUE.
  - If no request, stay in ARB.
- ISSUE state:
  - buf_rvalid=1, buf_raddr=latched address; both held stable for the whole state.
  - If buf_rready=1: capture buf_rdata into rsp_data, go to RESP.
  - Otherwise increment the counter. When counter reaches TIMEOUT_CYCLES-1 with buf_rready still low: set rsp_data=0, rsp_err=1, timeout_err=1, go to RESP.
  - buf_rvalid drops when leaving ISSUE.
- RESP state:
  - rsp_valid[g]=1 for exactly one cycle; rsp_data and rsp_err are valid that cycle.
  - Clear the counter and go to ARB.
  - rsp_err=0 in every non-timeout response; rsp_data holds its last value outside RESP.
- Latency:
  - Accept at cycle T, buf_rvalid at T+1.
  - If buf_rready arrives at T+1+k, rsp_valid is at T+2+k.
  - Best case is one read per 3 cycles.
- Fairness: with all requesters permanently valid, grants rotate 0,1,...,NUM_REQ-1,0,... and no requester waits more than NUM_REQ grants.
- Boundary conditions:
  - A new req_valid arriving during ISSUE/RESP is not accepted until ARB.
  - A timeout exactly on the cycle buf_rready rises is treated as success, since the ready check has priority.
  - buf_rready while not in ISSUE is ignored.
  - Address wrap needs no handling; addresses pass through unmodified.
- Counter width is log2(TIMEOUT_CYCLES)+1; no saturation is needed because it is cleared in RESP.

Decomposition:
- Package sad_buf_pkg:
  - log2 function.
  - arb_state_t enum {ARB, ISSUE, RESP}.
  - Default pixel/address width constants, shared with image_buffer.
- Sub-module rr_arbiter:
  - Combinational round-robin grant (req vector + pointer -> one-hot grant + index).
  - Pointer register lives in image_buffer_rd_arbiter.

Test Plan:
- Reset, then req_valid=2'b01, addr0=14'd123, buf_rready tied 1, buf_rdata=12'hABC:
  - req_ready[0] at T, buf_rvalid/raddr=123 at T+1, rsp_valid=2'b01 with rsp_data=12'hABC, rsp_err=0 at T+2.
- Both requesters valid continuously, addr0=10, addr1=20:
  - buf_raddr sequence 10,20,10,20.
  - rsp_valid alternates 01,10.
  - Each grant is exactly 3 cycles apart.
- buf_rready held low 5 cycles after buf_rvalid:
  - buf_rvalid and buf_raddr stay stable for 6 cycles.
  - Response arrives 1 cycle after buf_rready rises.
- buf_rready never asserted, TIMEOUT_CYCLES=64:
  - After 64 ISSUE cycles, rsp_valid pulses with rsp_err=1 and rsp_data=0.
  - timeout_err=1 and stays set.
  - The next request completes normally.
- rst_n=0 for one cycle while in ISSUE:
  - Next cycle all outputs are 0 and no rsp_valid is issued.
  - Pending requester 1 is then granted first only if requester 0 is idle, since the pointer resets to 0.
- req_valid[1] asserted while requester 0 is in ISSUE:
  - Requester 1 is granted in the ARB cycle after requester 0's RESP, not earlier.
